// File: rtl/tt_check_pkg.sv
// Shared types and constants for the tt_factory_checker slice.
// TT_CHECK_LFSR_EN selects the LFSR stimulus seed; otherwise the counter seed is used.
package tt_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P_RST,
    P_SETTLE,
    P_CNT,
    P_LOOP,
    DONE
  } state_t;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_RST  = 2'd1;
  localparam logic [1:0] PH_CNT  = 2'd2;
  localparam logic [1:0] PH_LOOP = 2'd3;

  // x^8+x^6+x^5+x^4+1 as shift-left feedback taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

`ifdef TT_CHECK_LFSR_EN
  localparam logic [7:0] STIM_SEED = LFSR_SEED;
`else
  localparam logic [7:0] STIM_SEED = 8'h00;
`endif

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      P_RST:   phase_of = PH_RST;
      P_CNT:   phase_of = PH_CNT;
      P_LOOP:  phase_of = PH_LOOP;
      default: phase_of = PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tt_check_stim8.sv
// 8-bit stimulus generator: LFSR when TT_CHECK_LFSR_EN is defined, else an incrementer.
// q runs one step ahead of the value being driven; the top registers the seed itself.
module tt_check_stim8
  import tt_check_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] q
);

  function automatic logic [7:0] step(input logic [7:0] v);
`ifdef TT_CHECK_LFSR_EN
    step = {v[6:0], ^(v & LFSR_TAPS)};
`else
    step = v + 8'd1;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst)       q <= STIM_SEED;
    else if (load) q <= step(STIM_SEED);
    else if (adv)  q <= step(q);
  end

endmodule

// File: rtl/tt_factory_checker.sv
// Host-less factory test sequencer for tt_um_factory_test: reset pass-through,
// counter and loopback phases. Stimulus flavour set by TT_CHECK_LFSR_EN.
module tt_factory_checker
  import tt_check_pkg::*;
#(
  parameter int PHASE_LEN = 256,
  parameter int SETTLE    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_rst_n,
  output logic [7:0] dut_ui_in,
  output logic [7:0] dut_uio_in,
  input  logic [7:0] dut_uo_out,
  input  logic [7:0] dut_uio_out,
  input  logic [7:0] dut_uio_oe,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [1:0] fail_phase
);

  localparam logic [15:0] LEN_M1 = 16'(PHASE_LEN - 1);
  localparam logic [15:0] SET_M1 = 16'(SETTLE - 1);

  state_t      state, state_d;
  logic [15:0] cnt;
  logic [7:0]  prev, stim_q;
  logic        launch, last, mis, stim_load, stim_adv;

  // DONE keeps busy high for its entry cycle, so start is ignored there too
  assign launch = start && !busy && (state == IDLE || state == DONE);
  assign last   = (state == P_SETTLE) ? (cnt == SET_M1) : (cnt == LEN_M1);

  tt_check_stim8 u_stim (
    .clk  (clk),
    .rst  (rst),
    .load (stim_load),
    .adv  (stim_adv),
    .q    (stim_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    stim_load = 1'b0;
    stim_adv  = 1'b0;
    mis       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (launch) begin
          state_d   = P_RST;
          stim_load = 1'b1;
        end
      end
      P_RST: begin
        stim_adv = !last;
        mis      = (dut_uo_out != dut_ui_in) || (dut_uio_oe != 8'h00);
        if (last) state_d = P_SETTLE;
      end
      P_SETTLE: if (last) state_d = P_CNT;
      P_CNT: begin
        stim_adv = last;
        // compare against the last sampled value so a skip costs one error
        mis      = ((cnt != 16'd0) && (dut_uo_out != prev + 8'd1)) ||
                   (dut_uio_out != dut_uo_out) || (dut_uio_oe != 8'hFF);
        if (last) state_d = P_LOOP;
      end
      P_LOOP: begin
        stim_adv = !last;
        mis      = (dut_uo_out != dut_uio_in) || (dut_uio_out != 8'h00) ||
                   (dut_uio_oe != 8'h00);
        if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      prev       <= '0;
      dut_rst_n  <= 1'b0;
      dut_ui_in  <= '0;
      dut_uio_in <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_phase <= PH_NONE;
    end else begin
      done <= 1'b0;
      cnt  <= (state_d != state) ? 16'd0 : cnt + 16'd1;
      if (launch) begin
        busy       <= 1'b1;
        pass       <= 1'b0;
        err_count  <= '0;
        fail_phase <= PH_NONE;
        dut_ui_in  <= STIM_SEED;
        dut_uio_in <= '0;
      end
      case (state)
        P_RST: begin
          if (last) begin
            dut_rst_n <= 1'b1;
            dut_ui_in <= 8'h01;
          end else begin
            dut_ui_in <= stim_q;
          end
        end
        P_CNT: begin
          prev <= dut_uo_out;
          if (last) begin
            dut_ui_in  <= 8'h00;
            dut_uio_in <= stim_q;
          end
        end
        P_LOOP: begin
          if (last) begin
            dut_rst_n  <= 1'b0;
            dut_uio_in <= 8'h00;
          end else begin
            dut_uio_in <= stim_q;
          end
        end
        DONE: begin
          if (busy) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == 8'd0);
          end
        end
        default: ;
      endcase
      if (mis) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (fail_phase == PH_NONE) fail_phase <= phase_of(state);
      end
    end
  end

endmodule

// File: tb/tb_tt_factory_checker.sv
// Directed bench: two checker instances (PHASE_LEN 16 and 300) each driving a
// behavioural tt_um_factory_test model with injectable faults.
module tb_tt_factory_checker;
  import tt_check_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       start   [2];
  logic       rst_n_d [2];
  logic [7:0] ui      [2];
  logic [7:0] uio_in  [2];
  logic [7:0] uo      [2];
  logic [7:0] uio_out [2];
  logic [7:0] oe      [2];
  logic       busy    [2];
  logic       done    [2];
  logic       pass    [2];
  logic [7:0] err     [2];
  logic [1:0] fph     [2];

  logic stuck3, tie55, oe_flt, skip;

  for (genvar c = 0; c < 2; c++) begin : g_model
    logic [7:0] mcnt, base;
    always_ff @(posedge clk)
      mcnt <= !rst_n_d[c] ? 8'h00 : mcnt + (skip ? 8'd2 : 8'd1);
    assign base       = rst_n_d[c] ? (ui[c][0] ? mcnt : uio_in[c]) : ui[c];
    assign uo[c]      = tie55 ? 8'h55 : (stuck3 ? (base & 8'hF7) : base);
    assign uio_out[c] = (rst_n_d[c] && ui[c][0]) ? mcnt : 8'h00;
    assign oe[c]      = (rst_n_d[c] && (ui[c][0] || oe_flt)) ? 8'hFF : 8'h00;
  end

  tt_factory_checker #(.PHASE_LEN(16), .SETTLE(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start[0]),
    .dut_rst_n(rst_n_d[0]), .dut_ui_in(ui[0]), .dut_uio_in(uio_in[0]),
    .dut_uo_out(uo[0]), .dut_uio_out(uio_out[0]), .dut_uio_oe(oe[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err[0]), .fail_phase(fph[0])
  );

  tt_factory_checker #(.PHASE_LEN(300), .SETTLE(4)) u_dut300 (
    .clk(clk), .rst(rst), .start(start[1]),
    .dut_rst_n(rst_n_d[1]), .dut_ui_in(ui[1]), .dut_uio_in(uio_in[1]),
    .dut_uo_out(uo[1]), .dut_uio_out(uio_out[1]), .dut_uio_oe(oe[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err[1]), .fail_phase(fph[1])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // snapshots taken during a run on channel 0
  logic       busy_1, rstn_1, rstn_17;
  logic [7:0] ui_1, ui_17, ui_37;

  // launches a run; lat = cycles from the start edge to done (0 if budget expires)
  task automatic run(input int c, input int budget, input int skip_at, input int poke_at,
                     output int lat);
    start[c] = 1'b1;
    tick();
    start[c] = 1'b0;
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      skip     = (i == skip_at);
      start[c] = (i == poke_at);
      tick();
      if (c == 0 && i == 1)  begin busy_1 = busy[0]; rstn_1 = rst_n_d[0]; ui_1 = ui[0]; end
      if (c == 0 && i == 17) begin rstn_17 = rst_n_d[0]; ui_17 = ui[0]; end
      if (c == 0 && i == 37) ui_37 = ui[0];
      if (done[c]) begin
        lat = i;
        break;
      end
    end
    skip     = 1'b0;
    start[c] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] ui1_exp;
`ifdef TT_CHECK_LFSR_EN
    ui1_exp = 8'h02;
`else
    ui1_exp = 8'h01;
`endif
    rst = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    stuck3 = 1'b0; tie55 = 1'b0; oe_flt = 1'b0; skip = 1'b0;
    repeat (3) tick();
    chk("rst_dut_rst_n", rst_n_d[0], 0);
    chk("rst_ui_in",     ui[0], 0);
    chk("rst_uio_in",    uio_in[0], 0);
    chk("rst_busy",      busy[0], 0);
    chk("rst_done",      done[0], 0);
    chk("rst_pass",      pass[0], 0);
    chk("rst_err_count", err[0], 0);
    chk("rst_fail_phase", fph[0], 0);
    rst = 1'b0;
    tick();

    // clean run, with a start pulse while busy that must be ignored
    run(0, 200, 0, 10, lat);
    chk("clean_latency", lat, 53);
    chk("clean_busy_1", busy_1, 1);
    chk("clean_rstn_1", rstn_1, 0);
    chk("clean_ui_1", ui_1, ui1_exp);
    chk("settle_rstn", rstn_17, 1);
    chk("settle_ui", ui_17, 8'h01);
    chk("loop_ui", ui_37, 8'h00);
    chk("clean_pass", pass[0], 1);
    chk("clean_err", err[0], 0);
    chk("clean_fail_phase", fph[0], 0);
    chk("clean_busy_done", busy[0], 0);
    tick();
    chk("done_one_cycle", done[0], 0);
    chk("done_dut_rst_n", rst_n_d[0], 0);
    repeat (5) tick();
    chk("pass_held", pass[0], 1);
    chk("no_restart", busy[0], 0);

    // uo_out[3] stuck low
    stuck3 = 1'b1;
    run(0, 200, 0, 0, lat);
    stuck3 = 1'b0;
    chk("stuck_latency", lat, 53);
    chk("stuck_err_nonzero", err[0] != 8'd0, 1);
    chk("stuck_fail_phase", fph[0], PH_RST);
    chk("stuck_pass", pass[0], 0);

    // counter jumps +2 once in the counter phase
    run(0, 200, 26, 0, lat);
    chk("skip_err", err[0], 1);
    chk("skip_fail_phase", fph[0], PH_CNT);
    chk("skip_pass", pass[0], 0);

    // output enables stuck on in loopback
    oe_flt = 1'b1;
    run(0, 200, 0, 0, lat);
    oe_flt = 1'b0;
    chk("oe_err", err[0], 16);
    chk("oe_fail_phase", fph[0], PH_LOOP);

    // reset mid-run: errors at ui=8..15 are counted by cycle 19
    stuck3 = 1'b1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (19) tick();
    chk("midrun_err_before", err[0], 8);
    chk("midrun_busy_before", busy[0], 1);
    rst = 1'b1;
    tick();
    chk("midrun_busy", busy[0], 0);
    chk("midrun_dut_rst_n", rst_n_d[0], 0);
    chk("midrun_err", err[0], 0);
    chk("midrun_fail_phase", fph[0], 0);
    chk("midrun_ui", ui[0], 0);
    rst = 1'b0;
    stuck3 = 1'b0;
    tick();

    // saturation: uo_out tied to 8'h55 over 300-cycle phases
    tie55 = 1'b1;
    run(1, 1200, 0, 0, lat);
    tie55 = 1'b0;
    chk("sat_err", err[1], 255);
    chk("sat_fail_phase", fph[1], PH_RST);
    chk("sat_pass", pass[1], 0);

    // clean long run: DUT counter wraps FF->00 in the counter phase
    run(1, 1200, 0, 0, lat);
    chk("wrap_latency", lat, 905);
    chk("wrap_pass", pass[1], 1);
    chk("wrap_err", err[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
